// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters, decode reservations,
// the regfile write/read ports and the PC load path.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                       req0_valid_i;
    logic [ADDR_WIDTH-1:0]      req0_addr_i;
    logic [DATA_WIDTH-1:0]      req0_data_i;
    logic                       req0_ready_o;
    logic                       req1_valid_i;
    logic [ADDR_WIDTH-1:0]      req1_addr_i;
    logic [DATA_WIDTH-1:0]      req1_data_i;
    logic                       req1_ready_o;
    logic                       reserve_valid_i;
    logic [ADDR_WIDTH-1:0]      reserve_addr_i;
    logic [ADDR_WIDTH-1:0]      read_addr_1_i;
    logic [ADDR_WIDTH-1:0]      read_addr_2_i;
    logic                       write_enable_o;
    logic [ADDR_WIDTH-1:0]      write_addr_o;
    logic [DATA_WIDTH-1:0]      write_data_o;
    logic                       pc_write_o;
    logic [DATA_WIDTH-1:0]      pc_data_o;
    logic                       hazard_1_o;
    logic                       hazard_2_o;
    logic [2**ADDR_WIDTH-1:0]   pending_o;

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        output reserve_valid_i, reserve_addr_i, read_addr_1_i, read_addr_2_i,
        input  req0_ready_o, req1_ready_o,
        input  write_enable_o, write_addr_o, write_data_o,
        input  pc_write_o, pc_data_o, hazard_1_o, hazard_2_o, pending_o
    );

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        input  reserve_valid_i, reserve_addr_i, read_addr_1_i, read_addr_2_i,
        output req0_ready_o, req1_ready_o,
        output write_enable_o, write_addr_o, write_data_o,
        output pc_write_o, pc_data_o, hazard_1_o, hazard_2_o, pending_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load
// writebacks, with R15 redirected to the PC and a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int PC_ADDR    = 15
) (
    input logic                 clk_i,
    input logic                 rst_i,
    regfile_wb_arbiter_if.slave bus
);
    localparam int                    NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_IDX   = ADDR_WIDTH'(PC_ADDR);

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_t;

    grant_t                  last_grant;
    grant_t                  last_grant_next;
    logic                    grant0;
    logic                    grant1;
    logic                    transfer;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic [NUM_REGS-1:0]     pending;
    logic [NUM_REGS-1:0]     pending_next;
    logic                    write_enable;
    logic [ADDR_WIDTH-1:0]   write_addr;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    pc_write;
    logic [DATA_WIDTH-1:0]   pc_data;

    // Grants are masked during reset so nothing transfers while the state is cleared.
    always_comb begin
        grant0          = 1'b0;
        grant1          = 1'b0;
        last_grant_next = last_grant;
        if (!rst_i) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                if (last_grant == GRANT_REQ1) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = bus.req0_valid_i;
                grant1 = bus.req1_valid_i;
            end
        end
        if (grant0) begin
            last_grant_next = GRANT_REQ0;
        end else if (grant1) begin
            last_grant_next = GRANT_REQ1;
        end
        transfer   = grant0 | grant1;
        grant_addr = grant1 ? bus.req1_addr_i : bus.req0_addr_i;
        grant_data = grant1 ? bus.req1_data_i : bus.req0_data_i;
    end

    // Reservation is applied after the clear so a same-cycle reserve wins.
    always_comb begin
        pending_next = pending;
        if (transfer) begin
            pending_next[grant_addr] = 1'b0;
        end
        if (bus.reserve_valid_i && (bus.reserve_addr_i != PC_IDX)) begin
            pending_next[bus.reserve_addr_i] = 1'b1;
        end
        pending_next[PC_IDX] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant   <= GRANT_REQ1;
            pending      <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            pc_write     <= 1'b0;
            pc_data      <= '0;
        end else begin
            last_grant   <= last_grant_next;
            pending      <= pending_next;
            write_enable <= 1'b0;
            pc_write     <= 1'b0;
            if (transfer) begin
                if (grant_addr == PC_IDX) begin
                    pc_write <= 1'b1;
                    pc_data  <= grant_data;
                end else begin
                    write_enable <= 1'b1;
                    write_addr   <= grant_addr;
                    write_data   <= grant_data;
                end
            end
        end
    end

    assign bus.req0_ready_o   = grant0;
    assign bus.req1_ready_o   = grant1;
    assign bus.write_enable_o = write_enable;
    assign bus.write_addr_o   = write_addr;
    assign bus.write_data_o   = write_data;
    assign bus.pc_write_o     = pc_write;
    assign bus.pc_data_o      = pc_data;
    assign bus.pending_o      = pending;
    assign bus.hazard_1_o     = (bus.read_addr_1_i != PC_IDX) && pending[bus.read_addr_1_i];
    assign bus.hazard_2_o     = (bus.read_addr_2_i != PC_IDX) && pending[bus.read_addr_2_i];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed writebacks push expected
// regfile/PC writes; a negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct {
        logic          is_pc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   check_count = 0;
    int   error_count = 0;
    exp_t exp_q[$];

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_ADDR(15)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic rv, input logic [AW-1:0] ra
    );
        bus.req0_valid_i    = v0;
        bus.req0_addr_i     = a0;
        bus.req0_data_i     = d0;
        bus.req1_valid_i    = v1;
        bus.req1_addr_i     = a1;
        bus.req1_data_i     = d1;
        bus.reserve_valid_i = rv;
        bus.reserve_addr_i  = ra;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_expect(input logic is_pc, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        e.is_pc = is_pc;
        e.addr  = addr;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every regfile write or PC load must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.write_enable_o || bus.pc_write_o) begin
            if (exp_q.size() == 0) begin
                check_count++;
                error_count++;
                $display("[TB] FAIL unexpected_write: we=%0b pc=%0b addr=0x%0h, expected none", bus.write_enable_o, bus.pc_write_o, bus.write_addr_o);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_write_enable", 32'(bus.write_enable_o), 32'(!e.is_pc));
                checkOutput("sb_pc_write", 32'(bus.pc_write_o), 32'(e.is_pc));
                if (e.is_pc) begin
                    checkOutput("sb_pc_data", bus.pc_data_o, e.data);
                end else begin
                    checkOutput("sb_write_addr", 32'(bus.write_addr_o), 32'(e.addr));
                    checkOutput("sb_write_data", bus.write_data_o, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.read_addr_1_i = 4'h0;
        bus.read_addr_2_i = 4'hF;
        applyStimulus(1'b1, 4'h1, 32'h1, 1'b1, 4'h2, 32'h2, 1'b1, 4'h3);
        sample();
        checkOutput("reset_ready0", 32'(bus.req0_ready_o), 32'd0);
        checkOutput("reset_ready1", 32'(bus.req1_ready_o), 32'd0);
        checkOutput("reset_we", 32'(bus.write_enable_o), 32'd0);
        checkOutput("reset_pc_write", 32'(bus.pc_write_o), 32'd0);
        checkOutput("reset_pending", 32'(bus.pending_o), 32'd0);
        checkOutput("reset_write_data", bus.write_data_o, 32'd0);

        // Single ALU write
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 4'hB, 32'hE00A6107, 1'b0, '0, '0, 1'b0, '0);
        sample();
        checkOutput("t1_ready0", 32'(bus.req0_ready_o), 32'd1);
        checkOutput("t1_ready1", 32'(bus.req1_ready_o), 32'd0);
        push_expect(1'b0, 4'hB, 32'hE00A6107);
        step();
        idle();
        step();
        sample();
        checkOutput("t1_we_drop", 32'(bus.write_enable_o), 32'd0);
        checkOutput("t1_addr_hold", 32'(bus.write_addr_o), 32'hB);

        // Round robin from reset
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 4'h3, 32'h1111_0003, 1'b1, 4'h5, 32'h2222_0005, 1'b0, '0);
        sample();
        checkOutput("t2_g1_ready0", 32'(bus.req0_ready_o), 32'd1);
        checkOutput("t2_g1_ready1", 32'(bus.req1_ready_o), 32'd0);
        push_expect(1'b0, 4'h3, 32'h1111_0003);
        step();
        sample();
        checkOutput("t2_g2_ready0", 32'(bus.req0_ready_o), 32'd0);
        checkOutput("t2_g2_ready1", 32'(bus.req1_ready_o), 32'd1);
        push_expect(1'b0, 4'h5, 32'h2222_0005);
        step();
        sample();
        checkOutput("t2_g3_ready0", 32'(bus.req0_ready_o), 32'd1);
        checkOutput("t2_g3_ready1", 32'(bus.req1_ready_o), 32'd0);
        push_expect(1'b0, 4'h3, 32'h1111_0003);
        step();
        idle();

        // Load to R15 goes to the PC path
        applyStimulus(1'b0, '0, '0, 1'b1, 4'hF, 32'h54001147, 1'b0, '0);
        sample();
        checkOutput("t3_ready1", 32'(bus.req1_ready_o), 32'd1);
        checkOutput("t3_ready0", 32'(bus.req0_ready_o), 32'd0);
        push_expect(1'b1, 4'hF, 32'h54001147);
        step();
        idle();
        sample();
        checkOutput("t3_no_we", 32'(bus.write_enable_o), 32'd0);
        step();
        sample();
        checkOutput("t3_pc_pulse_end", 32'(bus.pc_write_o), 32'd0);
        checkOutput("t3_pc_data_hold", bus.pc_data_o, 32'h54001147);

        // Reserve then clear R7
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'h7);
        bus.read_addr_1_i = 4'h7;
        sample();
        checkOutput("t4_hazard_before", 32'(bus.hazard_1_o), 32'd0);
        step();
        idle();
        sample();
        checkOutput("t4_hazard_set", 32'(bus.hazard_1_o), 32'd1);
        checkOutput("t4_hazard2_pc", 32'(bus.hazard_2_o), 32'd0);
        checkOutput("t4_pending", 32'(bus.pending_o), 32'h0080);
        step();
        applyStimulus(1'b1, 4'h7, 32'hCAFE0007, 1'b0, '0, '0, 1'b0, '0);
        sample();
        checkOutput("t4_ready0", 32'(bus.req0_ready_o), 32'd1);
        checkOutput("t4_hazard_held", 32'(bus.hazard_1_o), 32'd1);
        push_expect(1'b0, 4'h7, 32'hCAFE0007);
        step();
        idle();
        sample();
        checkOutput("t4_hazard_clear", 32'(bus.hazard_1_o), 32'd0);
        checkOutput("t4_pending_clear", 32'(bus.pending_o), 32'h0000);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'hF);
        step();
        idle();
        sample();
        checkOutput("t4_pc_reserve_ignored", 32'(bus.pending_o), 32'h0000);
        checkOutput("t4_hazard2_pc_after", 32'(bus.hazard_2_o), 32'd0);

        // Reserve beats clear on the same address
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'h5);
        step();
        applyStimulus(1'b1, 4'h5, 32'h0000_0055, 1'b0, '0, '0, 1'b1, 4'h5);
        sample();
        checkOutput("t5_pending5_before", 32'(bus.pending_o[5]), 32'd1);
        checkOutput("t5_ready0", 32'(bus.req0_ready_o), 32'd1);
        push_expect(1'b0, 4'h5, 32'h0000_0055);
        step();
        idle();
        sample();
        checkOutput("t5_reserve_wins", 32'(bus.pending_o[5]), 32'd1);

        // Asynchronous reset mid-transfer
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'h7);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'hB);
        step();
        applyStimulus(1'b1, 4'h2, 32'h0000_0002, 1'b0, '0, '0, 1'b0, '0);
        sample();
        checkOutput("t6_pending_pre", 32'(bus.pending_o), 32'h0880);
        checkOutput("t6_ready0_pre", 32'(bus.req0_ready_o), 32'd1);
        push_expect(1'b0, 4'h2, 32'h0000_0002);
        step();
        applyStimulus(1'b1, 4'h3, 32'h3333_0003, 1'b1, 4'h4, 32'h4444_0004, 1'b0, '0);
        sample();
        checkOutput("t6_we_before_reset", 32'(bus.write_enable_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_we", 32'(bus.write_enable_o), 32'd0);
        checkOutput("t6_async_addr", 32'(bus.write_addr_o), 32'd0);
        checkOutput("t6_async_data", bus.write_data_o, 32'd0);
        checkOutput("t6_async_pending", 32'(bus.pending_o), 32'd0);
        checkOutput("t6_async_pc_data", bus.pc_data_o, 32'd0);
        checkOutput("t6_async_ready0", 32'(bus.req0_ready_o), 32'd0);
        checkOutput("t6_async_ready1", 32'(bus.req1_ready_o), 32'd0);
        step();
        rst = 1'b0;
        sample();
        checkOutput("t6_post_ready0", 32'(bus.req0_ready_o), 32'd1);
        checkOutput("t6_post_ready1", 32'(bus.req1_ready_o), 32'd0);
        push_expect(1'b0, 4'h3, 32'h3333_0003);
        step();
        bus.req0_valid_i = 1'b0;
        sample();
        checkOutput("t6_post_ready1_next", 32'(bus.req1_ready_o), 32'd1);
        push_expect(1'b0, 4'h4, 32'h4444_0004);
        step();
        idle();

        step();
        step();
        sample();
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 = ALU/execute result, req1 = load/memory result.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the granted write toward the regfile's write_enable_i/write_addr_i/write_data_i.
- Diverts writes to R15 to the PC path, since the regfile sources R15 from r_15_i.
- Keeps a 16-bit pending-write scoreboard and reports read hazards for the two regfile read addresses.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 4, register address width (2**ADDR_WIDTH registers).
- PC_ADDR, 15, register index that is redirected to the PC path instead of the regfile.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req0_valid_i  in  1  ALU writeback request.
- req0_addr_i  in  ADDR_WIDTH  ALU destination register.
- req0_data_i  in  DATA_WIDTH  ALU result.
- req0_ready_o  out  1  req0 granted this cycle (combinational).
- req1_valid_i  in  1  load writeback request.
- req1_addr_i  in  ADDR_WIDTH  load destination register.
- req1_data_i  in  DATA_WIDTH  load data.
- req1_ready_o  out  1  req1 granted this cycle (combinational).
- reserve_valid_i  in  1  decode reserves a destination register.
- reserve_addr_i  in  ADDR_WIDTH  register being reserved.
- read_addr_1_i  in  ADDR_WIDTH  regfile read port 1 address (hazard check).
- read_addr_2_i  in  ADDR_WIDTH  regfile read port 2 address (hazard check).
- write_enable_o  out  1  to regfile write_enable_i.
- write_addr_o  out  ADDR_WIDTH  to regfile write_addr_i.
- write_data_o  out  DATA_WIDTH  to regfile write_data_i.
- pc_write_o  out  1  one-cycle pulse: PC load.
- pc_data_o  out  DATA_WIDTH  new PC value.
- hazard_1_o  out  1  read_addr_1_i has a pending write.
- hazard_2_o  out  1  read_addr_2_i has a pending write.
- pending_o  out  2**ADDR_WIDTH  scoreboard bits.

Behaviour:
- Reset (asynchronous, active-high): write_enable_o=0, write_addr_o=0, write_data_o=0, pc_write_o=0, pc_data_o=0, pending_o=0, last_grant=1 (req0 wins the first conflict). ready outputs are combinational and are 0 while rst_i=1.
- Arbitration (combinational):
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on a cycle with a grant.
  - Exactly one ready_o high per granted cycle. A transfer occurs when valid && ready.
- Requester obligations: a requester not granted holds valid, addr and data stable until granted. No ready is given without valid.
- Latency: transfer at edge N produces outputs during cycle N+1; the regfile captures at edge N+1.
- Normal write (granted addr != PC_ADDR): write_enable_o=1, write_addr_o=addr, write_data_o=data, all for exactly one cycle.
- PC write (granted addr == PC_ADDR): write_enable_o=0, pc_write_o=1, pc_data_o=data, for one cycle.
- Idle cycles: write_enable_o=0 and pc_write_o=0. Address and data outputs hold their last values.
- Scoreboard update at each edge:
  - On reserve_valid_i, set pending[reserve_addr_i].
  - On a transfer, clear pending[granted addr].
  - Reserve and clear of the same address in one cycle: the bit ends set (reserve wins).
  - Reserving an already-pending register leaves it set; there is no counting.
  - Reserving PC_ADDR is ignored; that bit always reads 0.
- Hazards (combinational): hazard_k_o = pending[read_addr_k_i]. Always 0 for PC_ADDR.
- Writes to a register with no pending bit are accepted normally; the clear is a no-op.
- Reset asserted mid-transfer: the in-flight write is dropped and the scoreboard is cleared. After release, arbitration restarts with req0 priority.

Test Plan:
- Reset, then req0 valid with addr=4'hB, data=32'hE00A6107 -> req0_ready_o=1 that cycle; next cycle write_enable_o=1, write_addr_o=4'hB, write_data_o=32'hE00A6107; the cycle after, write_enable_o=0.
- Both valid from reset (req0 addr 3, req1 addr 5), held -> grants go req0, req1, req0 on consecutive cycles; write_addr_o sequence is 3, 5, 3.
- req1 valid with addr=4'hF, data=32'h54001147 -> pc_write_o=1 with pc_data_o=32'h54001147 for one cycle; write_enable_o stays 0.
- reserve addr 7, then read_addr_1_i=7 -> hazard_1_o=1. After a req0 write to 7 is granted, hazard_1_o=0 on the following cycle. read_addr_2_i=4'hF -> hazard_2_o=0 throughout.
- reserve addr 5 in the same cycle req0 writes 5, with bit 5 previously set -> pending_o[5] remains 1.
- Assert rst_i asynchronously while write_enable_o=1 and pending_o=16'h0880 -> all outputs go to 0 immediately. After release with both requesters valid, req0 is granted first.
